// File: rtl/usb_token_rx.sv
// USB token receiver: validates the PID, shifts the 11-bit token field through a bit-serial CRC5 and reports tokens.
// Defining USB_TOKEN_SOF_EN also decodes SOF packets (PID 0x5) and adds the tok_frame output.
module usb_token_rx (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_sop,
   input  logic        rx_eop,
   output logic        rx_ready,
   output logic        tok_valid,
   output logic [3:0]  tok_pid,
   output logic [6:0]  tok_addr,
   output logic [3:0]  tok_endp,
   output logic        tok_err,
   output logic [1:0]  tok_err_code
`ifdef USB_TOKEN_SOF_EN
   ,
   output logic [10:0] tok_frame
`endif
);

   typedef enum logic [2:0] {IDLE, WAIT_B0, SHIFT_B0, WAIT_B1, SHIFT_B1, WAIT_EOP, DRAIN} state_t;

   localparam logic [1:0] ERR_PID = 2'b01;
   localparam logic [1:0] ERR_CRC = 2'b10;
   localparam logic [1:0] ERR_LEN = 2'b11;

   state_t      state_q, state_d;
   logic [4:0]  crc_q, crc_d;
   logic        eop_seen_q, eop_seen_d;
   logic        tok_valid_q, tok_valid_d;
   logic        tok_err_q, tok_err_d;
   logic [1:0]  tok_err_code_q, tok_err_code_d;
   logic [3:0]  tok_pid_q, tok_pid_d;
   logic [6:0]  tok_addr_q, tok_addr_d;
   logic [3:0]  tok_endp_q, tok_endp_d;
`ifdef USB_TOKEN_SOF_EN
   logic [10:0] tok_frame_q, tok_frame_d;
`endif
   logic [7:0]  sh_q, sh_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [10:0] field_q, field_d;
   logic [4:0]  crc_rx_q, crc_rx_d;
   logic [3:0]  pid_q, pid_d;

   logic        byte_acc;
   logic        do_report;
   logic [4:0]  crc_step, rep_crc;
   logic [10:0] field_step, rep_field;

   function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
      logic fb;
      fb = c[4] ^ b;
      return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
   endfunction

   // The wire carries the inverted CRC MSB first, so byte1[3] holds ~c[4].
   function automatic logic crc5_match(input logic [4:0] c, input logic [4:0] rx);
      return rx == ~{c[0], c[1], c[2], c[3], c[4]};
   endfunction

   function automatic logic is_token(input logic [3:0] pid);
      case (pid)
         4'h1, 4'h9, 4'hD: return 1'b1;
`ifdef USB_TOKEN_SOF_EN
         4'h5:             return 1'b1;
`endif
         default:          return 1'b0;
      endcase
   endfunction

   assign rx_ready = ~rst & (state_q inside {IDLE, WAIT_B0, WAIT_B1, WAIT_EOP, DRAIN});

   always_comb begin
      byte_acc       = rx_valid & rx_ready;
      crc_step       = crc5_step(crc_q, sh_q[0]);
      field_step     = {sh_q[0], field_q[10:1]};
      state_d        = state_q;
      crc_d          = crc_q;
      eop_seen_d     = eop_seen_q | (rx_eop & (state_q != IDLE));
      tok_valid_d    = 1'b0;
      tok_err_d      = 1'b0;
      tok_err_code_d = tok_err_code_q;
      tok_pid_d      = tok_pid_q;
      tok_addr_d     = tok_addr_q;
      tok_endp_d     = tok_endp_q;
`ifdef USB_TOKEN_SOF_EN
      tok_frame_d    = tok_frame_q;
`endif
      sh_d           = sh_q;
      cnt_d          = cnt_q;
      field_d        = field_q;
      crc_rx_d       = crc_rx_q;
      pid_d          = pid_q;
      do_report      = 1'b0;
      rep_crc        = crc_q;
      rep_field      = field_q;

      // A start-of-packet byte always restarts decoding, whatever was in flight.
      if (byte_acc && rx_sop) begin
         eop_seen_d = 1'b0;
         crc_d      = 5'h1F;
         pid_d      = rx_data[3:0];
         if (rx_data[7:4] != ~rx_data[3:0]) begin
            tok_err_d      = 1'b1;
            tok_err_code_d = ERR_PID;
            state_d        = DRAIN;
         end else if (is_token(rx_data[3:0])) begin
            state_d = WAIT_B0;
         end else begin
            state_d = DRAIN;
         end
      end else begin
         case (state_q)
            IDLE: ;
            WAIT_B0, WAIT_B1: begin
               if (rx_eop || eop_seen_q) begin
                  tok_err_d      = 1'b1;
                  tok_err_code_d = ERR_LEN;
                  state_d        = IDLE;
               end else if (byte_acc) begin
                  cnt_d = 3'd0;
                  if (state_q == WAIT_B0) begin
                     sh_d    = rx_data;
                     state_d = SHIFT_B0;
                  end else begin
                     sh_d     = {5'b00000, rx_data[2:0]};
                     crc_rx_d = rx_data[7:3];
                     state_d  = SHIFT_B1;
                  end
               end
            end
            SHIFT_B0, SHIFT_B1: begin
               crc_d   = crc_step;
               field_d = field_step;
               sh_d    = sh_q >> 1;
               cnt_d   = cnt_q + 3'd1;
               if (state_q == SHIFT_B0) begin
                  if (rx_eop) begin
                     tok_err_d      = 1'b1;
                     tok_err_code_d = ERR_LEN;
                     state_d        = IDLE;
                  end else if (cnt_q == 3'd7) begin
                     state_d = WAIT_B1;
                  end
               end else if (cnt_q == 3'd2) begin
                  if (eop_seen_q || rx_eop) begin
                     do_report = 1'b1;
                     rep_crc   = crc_step;
                     rep_field = field_step;
                     state_d   = IDLE;
                  end else begin
                     state_d = WAIT_EOP;
                  end
               end
            end
            WAIT_EOP: begin
               if (byte_acc) begin
                  tok_err_d      = 1'b1;
                  tok_err_code_d = ERR_LEN;
                  state_d        = rx_eop ? IDLE : DRAIN;
               end else if (rx_eop) begin
                  do_report = 1'b1;
                  state_d   = IDLE;
               end
            end
            DRAIN: if (rx_eop) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      if (do_report) begin
         if (crc5_match(rep_crc, crc_rx_q)) begin
            tok_valid_d = 1'b1;
            tok_pid_d   = pid_q;
            tok_addr_d  = rep_field[6:0];
            tok_endp_d  = rep_field[10:7];
`ifdef USB_TOKEN_SOF_EN
            tok_frame_d = rep_field;
`endif
         end else begin
            tok_err_d      = 1'b1;
            tok_err_code_d = ERR_CRC;
         end
      end

      if (state_d == IDLE) eop_seen_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         crc_q          <= 5'h1F;
         eop_seen_q     <= 1'b0;
         tok_valid_q    <= 1'b0;
         tok_err_q      <= 1'b0;
         tok_err_code_q <= 2'b00;
         tok_pid_q      <= 4'h0;
         tok_addr_q     <= 7'h00;
         tok_endp_q     <= 4'h0;
`ifdef USB_TOKEN_SOF_EN
         tok_frame_q    <= 11'h000;
`endif
      end else begin
         state_q        <= state_d;
         crc_q          <= crc_d;
         eop_seen_q     <= eop_seen_d;
         tok_valid_q    <= tok_valid_d;
         tok_err_q      <= tok_err_d;
         tok_err_code_q <= tok_err_code_d;
         tok_pid_q      <= tok_pid_d;
         tok_addr_q     <= tok_addr_d;
         tok_endp_q     <= tok_endp_d;
`ifdef USB_TOKEN_SOF_EN
         tok_frame_q    <= tok_frame_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      field_q  <= field_d;
      crc_rx_q <= crc_rx_d;
      pid_q    <= pid_d;
   end

   assign tok_valid    = tok_valid_q;
   assign tok_err      = tok_err_q;
   assign tok_err_code = tok_err_code_q;
   assign tok_pid      = tok_pid_q;
   assign tok_addr     = tok_addr_q;
   assign tok_endp     = tok_endp_q;
`ifdef USB_TOKEN_SOF_EN
   assign tok_frame    = tok_frame_q;
`endif

endmodule

// File: tb/tb_usb_token_rx.sv
// Directed bench for usb_token_rx: expected reports are queued as stimulus is driven and popped when a pulse appears.
module tb_usb_token_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_sop = 1'b0;
   logic        rx_eop = 1'b0;
   logic        rx_ready;
   logic        tok_valid;
   logic [3:0]  tok_pid;
   logic [6:0]  tok_addr;
   logic [3:0]  tok_endp;
   logic        tok_err;
   logic [1:0]  tok_err_code;
`ifdef USB_TOKEN_SOF_EN
   logic [10:0] tok_frame;
`endif

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        is_err;
      logic [1:0]  code;
      logic [3:0]  pid;
      logic [6:0]  addr;
      logic [3:0]  endp;
      logic [10:0] frame;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   usb_token_rx dut (
      .clk(clk),
      .rst(rst),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_sop(rx_sop),
      .rx_eop(rx_eop),
      .rx_ready(rx_ready),
      .tok_valid(tok_valid),
      .tok_pid(tok_pid),
      .tok_addr(tok_addr),
      .tok_endp(tok_endp),
      .tok_err(tok_err),
      .tok_err_code(tok_err_code)
`ifdef USB_TOKEN_SOF_EN
      , .tok_frame(tok_frame)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk_ok(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
      exp_t e;
      e.is_err = 1'b0; e.code = 2'b00; e.pid = pid; e.addr = addr; e.endp = endp;
      e.frame = {endp, addr}; e.cyc = 0;
      return e;
   endfunction

   function automatic exp_t mk_err(input logic [1:0] code);
      exp_t e;
      e.is_err = 1'b1; e.code = code; e.pid = 4'h0; e.addr = 7'h00; e.endp = 4'h0;
      e.frame = 11'h000; e.cyc = 0;
      return e;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (rx_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("rx_ready_wait", 32'(rx_ready), 32'd1);
   endtask

   // Drives one byte at a negedge; a pushed expectation is due the cycle after acceptance.
   task automatic send_byte(input logic [7:0] d, input logic sop, input bit push, input exp_t ex, output int t);
      wait_ready();
      rx_data = d; rx_sop = sop; rx_valid = 1'b1; t = cyc;
      if (push) begin ex.cyc = t + 1; sb.push_back(ex); end
      @(negedge clk);
      rx_valid = 1'b0; rx_sop = 1'b0; rx_data = 8'h00;
   endtask

   task automatic send_eop(input bit push, input exp_t ex, input int min_cyc);
      rx_eop = 1'b1;
      if (push) begin ex.cyc = (cyc + 1 > min_cyc) ? cyc + 1 : min_cyc; sb.push_back(ex); end
      @(negedge clk);
      rx_eop = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (tok_valid === 1'b1 || tok_err === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'({tok_valid, tok_err}), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("tok_valid", 32'(tok_valid), 32'(!e.is_err));
            chk("tok_err", 32'(tok_err), 32'(e.is_err));
            if (e.is_err) begin
               chk("tok_err_code", 32'(tok_err_code), 32'(e.code));
            end else begin
               chk("tok_pid", 32'(tok_pid), 32'(e.pid));
               chk("tok_addr", 32'(tok_addr), 32'(e.addr));
               chk("tok_endp", 32'(tok_endp), 32'(e.endp));
`ifdef USB_TOKEN_SOF_EN
               chk("tok_frame", 32'(tok_frame), 32'(e.frame));
`endif
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int   t, u;
      exp_t none;
      bit   sof_en;
      none = mk_err(2'b00);
`ifdef USB_TOKEN_SOF_EN
      sof_en = 1'b1;
`else
      sof_en = 1'b0;
`endif

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rx_ready", 32'(rx_ready), 32'd0);
      chk("rst_pulses", 32'({tok_valid, tok_err, tok_err_code}), 32'd0);
      chk("rst_fields", 32'({tok_pid, tok_addr, tok_endp}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_rx_ready", 32'(rx_ready), 32'd1);

      // SETUP addr 0 endp 0 with rx_ready timing
      send_byte(8'h2D, 1'b1, 1'b0, none, t);
      send_byte(8'h00, 1'b0, 1'b0, none, t);
      for (int i = 0; i < 8; i++) begin
         chk("shift_b0_ready_low", 32'(rx_ready), 32'd0);
         @(negedge clk);
      end
      chk("wait_b1_ready_high", 32'(rx_ready), 32'd1);
      send_byte(8'h10, 1'b0, 1'b0, none, u);
      send_eop(1'b1, mk_ok(4'hD, 7'h00, 4'h0), u + 4);
      chk("shift_b1_ready_low", 32'(rx_ready), 32'd0);
      @(negedge clk);
      chk("shift_b1_ready_low_last", 32'(rx_ready), 32'd0);
      @(negedge clk);
      chk("idle_after_report", 32'(rx_ready), 32'd1);
      wait_cycles(3);

      // CRC error
      send_byte(8'h2D, 1'b1, 1'b0, none, t);
      send_byte(8'h00, 1'b0, 1'b0, none, t);
      send_byte(8'h18, 1'b0, 1'b0, none, u);
      send_eop(1'b1, mk_err(2'b10), u + 4);
      wait_cycles(5);

      // OUT addr 0x15 endp 0xE (CRC field 5'b11101)
      send_byte(8'hE1, 1'b1, 1'b0, none, t);
      send_byte(8'h15, 1'b0, 1'b0, none, t);
      send_byte(8'hEF, 1'b0, 1'b0, none, u);
      send_eop(1'b1, mk_ok(4'h1, 7'h15, 4'hE), u + 4);
      wait_cycles(5);

      // PID check error, then discarded bytes until EOP
      send_byte(8'h2E, 1'b1, 1'b1, mk_err(2'b01), t);
      send_byte(8'h00, 1'b0, 1'b0, none, t);
      send_byte(8'h10, 1'b0, 1'b0, none, t);
      chk("drain_ready", 32'(rx_ready), 32'd1);
      send_eop(1'b0, none, 0);
      wait_cycles(3);

      // Length error: EOP after one field byte
      send_byte(8'h69, 1'b1, 1'b0, none, t);
      send_byte(8'h00, 1'b0, 1'b0, none, t);
      wait_ready();
      send_eop(1'b1, mk_err(2'b11), 0);
      wait_cycles(3);

      // Length error: extra byte in WAIT_EOP
      send_byte(8'h69, 1'b1, 1'b0, none, t);
      send_byte(8'h00, 1'b0, 1'b0, none, t);
      send_byte(8'h10, 1'b0, 1'b0, none, u);
      send_byte(8'h55, 1'b0, 1'b1, mk_err(2'b11), t);
      chk("len_err_t", t, u + 4);
      wait_cycles(2);
      send_eop(1'b0, none, 0);
      wait_cycles(3);

      // IN addr 0x3A endp 0xA with a late EOP
      send_byte(8'h69, 1'b1, 1'b0, none, t);
      send_byte(8'h3A, 1'b0, 1'b0, none, t);
      send_byte(8'h3D, 1'b0, 1'b0, none, u);
      wait_cycles(5);
      send_eop(1'b1, mk_ok(4'h9, 7'h3A, 4'hA), u + 4);
      wait_cycles(3);

      // DATA0 packet is dropped silently
      send_byte(8'hC3, 1'b1, 1'b0, none, t);
      send_byte(8'hAA, 1'b0, 1'b0, none, t);
      send_byte(8'h55, 1'b0, 1'b0, none, t);
      send_eop(1'b0, none, 0);
      wait_cycles(3);
      chk("data0_idle_ready", 32'(rx_ready), 32'd1);

      // SOF: decoded only when enabled
      send_byte(8'hA5, 1'b1, 1'b0, none, t);
      send_byte(8'h3A, 1'b0, 1'b0, none, t);
      send_byte(8'h3D, 1'b0, 1'b0, none, u);
      send_eop(sof_en, mk_ok(4'h5, 7'h3A, 4'hA), u + 4);
      wait_cycles(5);
      chk("hold_tok_pid", 32'(tok_pid), sof_en ? 32'h5 : 32'h9);
      chk("hold_tok_addr", 32'(tok_addr), 32'h3A);

      // Reset in the middle of SHIFT_B0
      send_byte(8'h2D, 1'b1, 1'b0, none, t);
      send_byte(8'h00, 1'b0, 1'b0, none, t);
      wait_cycles(2);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
      chk("midrst_pulses", 32'({tok_valid, tok_err, tok_err_code}), 32'd0);
      chk("midrst_fields", 32'({tok_pid, tok_addr, tok_endp}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_idle_ready", 32'(rx_ready), 32'd1);
      wait_cycles(12);

      // New SOP while waiting for byte 1 restarts cleanly
      send_byte(8'h2D, 1'b1, 1'b0, none, t);
      send_byte(8'h00, 1'b0, 1'b0, none, t);
      send_byte(8'h2D, 1'b1, 1'b0, none, t);
      chk("restart_in_wait_b1", t, t);
      send_byte(8'h00, 1'b0, 1'b0, none, t);
      send_byte(8'h10, 1'b0, 1'b0, none, u);
      send_eop(1'b1, mk_ok(4'hD, 7'h00, 4'h0), u + 4);
      wait_cycles(6);

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
